uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
- UART receive front end. Oversamples the serial line, detects and validates the start bit, and shifts in data bits LSB first, then the parity bit, then checks the stop bit.
- Presents the captured word and parity bit to the downstream parity checker with a one-cycle load strobe, which maps directly onto that stage's data_in, parity_in and parity_load.
- Sits between the baud-rate generator (source of baud_tick) and the parity checker.

Parameters:
- OVERSAMPLE, 16: baud_tick pulses per bit period. Must be a power of 2 and at least 8.
- DATA_BITS, 8: data bits per frame. The downstream checker is fixed at 8.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- rx_in, input, 1: raw serial line. Idles high. Asynchronous to clock.
- baud_tick, input, 1: one-cycle enable at OVERSAMPLE x baud rate.
- rx_data, output, DATA_BITS: last received word. Bit 0 is the first bit received.
- rx_parity, output, 1: last received parity bit.
- parity_load, output, 1: one-cycle strobe. rx_data and rx_parity are valid in the same cycle.
- stop_error, output, 1: the last frame had its stop bit sampled low.
- rx_busy, output, 1: high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset values: rx_data=0, rx_parity=0, parity_load=0, stop_error=0, rx_busy=0, state=IDLE, counters=0, synchronizer flops=1, armed=1.
- Synchronization: rx_in passes through a 2-flop synchronizer to produce rx_s. The FSM uses only rx_s, so there are 2 cycles of latency from the line.
- Counters:
  - tick_cnt has log2(OVERSAMPLE) bits and advances only on baud_tick. It wraps from OVERSAMPLE-1 to 0, and each wrap is a bit boundary.
  - bit_cnt counts data bits, 0 to DATA_BITS-1.
- Sample point: SP = OVERSAMPLE/2-1, which is 7 at default. The sampled value is rx_s at SP, or the majority vote (see Optional Feature).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If rx_s==1, set armed=1.
  - On baud_tick with rx_s==0 and armed==1: go to START with tick_cnt=0.
- START:
  - At the sample point, if the sample is 1 (false start/glitch): go to IDLE. No strobe, outputs unchanged.
  - If the sample is 0: continue. On the tick_cnt wrap, go to DATA with bit_cnt=0.
- DATA:
  - At the sample point, shift the sample into a shift register from the MSB end so the first bit lands in bit 0.
  - On wrap: if bit_cnt==DATA_BITS-1, go to PARITY; otherwise increment bit_cnt.
- PARITY:
  - At the sample point, latch the parity bit internally.
  - On wrap, go to STOP.
- STOP: at the sample point, in a single cycle:
  - rx_data <= shift register
  - rx_parity <= latched parity bit
  - stop_error <= ~sample
  - parity_load=1 for exactly that cycle
  - state <= IDLE, which exits half a bit early to allow resynchronization to the next start edge
  - armed <= sample, so a low stop bit (break/framing error) blocks new start detection until rx_s returns high
- Strobe and error rules:
  - parity_load pulses on every completed frame, including frames with a framing error.
  - stop_error updates only at that strobe and holds until the next strobe.
- Output hold: rx_data and rx_parity hold between strobes. A false start, or reset_n deasserting mid-frame, never produces a strobe.
- Mid-frame reset: asynchronously returns everything to reset values. The partial frame is discarded.
- baud_tick low: the FSM freezes. rx_s sampling continues.
- Ticks and stuck-low line: back-to-back baud_tick on every clock is legal. A line held low forever gives one frame with stop_error=1, then the FSM waits in IDLE with armed=0.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN
- Defined:
  - Each bit is sampled at tick_cnt = SP-1, SP and SP+1.
  - The decision is the majority of the 3 samples, taken at SP+1. All "at the sample point" actions happen at SP+1.
  - The start bit is validated by the same vote.
- Undefined: single sample at SP. No extra flops.

Test Plan:
- Nominal frame: baud_tick every cycle, OVERSAMPLE=16. Send start, data 0xA5 LSB first, parity 0, stop 1 → exactly one parity_load pulse with rx_data=0xA5, rx_parity=0, stop_error=0. rx_busy is high from start detection until the strobe cycle.
- Parity pass-through: send 0x01 with parity 0 → rx_data=0x01, rx_parity=0. Downstream raises parity_error=1. The deframer itself flags nothing.
- Glitch: pull rx_in low for 4 ticks, then high → returns to IDLE, no parity_load, rx_data keeps its prior value.
  - With UART_RX_MAJORITY_EN: a single-tick low spike at SP inside a data bit of 0xFF is rejected, and rx_data=0xFF.
- Framing error: send 0x3C with the stop bit low, then hold rx_in low for 40 ticks → one strobe with rx_data=0x3C, stop_error=1. No second frame until rx_in goes high. The next valid 0x55 frame gives stop_error=0.
- Reset mid-frame: assert reset_n low during DATA bit 4 → all outputs read 0 immediately. After release, a full 0x81 frame gives a single strobe with rx_data=0x81.
- Back-to-back: two frames 0x12, 0x34 with no idle gap. baud_tick every 3rd cycle → two strobes, rx_data=0x12 then 0x34, both stop_error=0.

Source files
------------

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : UART receive front end. Synchronizes the serial line, validates
//            the start bit, shifts in DATA_BITS data bits LSB first followed
//            by a parity bit, checks the stop bit, and hands the word and
//            parity bit to the parity checker with a one-cycle load strobe.
// Ports    : clock       - system clock, rising edge
//            reset_n     - asynchronous active-low reset
//            rx_in       - raw serial line (idles high, asynchronous)
//            baud_tick   - one-cycle enable at OVERSAMPLE x baud rate
//            rx_data     - last received word, bit 0 = first bit received
//            rx_parity   - last received parity bit
//            parity_load - one-cycle strobe, rx_data/rx_parity valid with it
//            stop_error  - last frame had its stop bit sampled low
//            rx_busy     - frame in progress
// Options  : UART_RX_MAJORITY_EN - 3-sample majority vote around the bit
//            centre; the decision is taken one tick after the centre.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16,  // power of 2, >= 8
    parameter int DATA_BITS  = 8    // >= 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_in,
    input  logic                 baud_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity,
    output logic                 parity_load,
    output logic                 stop_error,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] C_SP       = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
    logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
    logic                 r_armed, w_armed_nxt;
    logic                 r_sync1, r_rx_s;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_parity;
    logic                 r_parity_load;
    logic                 r_stop_error;
    logic                 w_at_sp;
    logic                 w_wrap;
    logic                 w_sample;
    logic                 w_shift_en;
    logic                 w_par_en;
    logic                 w_load;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_wrap = (r_tick_cnt == C_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic r_maj_a, r_maj_b;

    // Capture the two samples preceding the decision tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else if (baud_tick) begin
            if (r_tick_cnt == C_SP - TW'(1)) r_maj_a <= r_rx_s;
            if (r_tick_cnt == C_SP)          r_maj_b <= r_rx_s;
        end
    end

    assign w_at_sp  = (r_tick_cnt == C_SP + TW'(1));
    assign w_sample = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_s) | (r_maj_b & r_rx_s);
`else
    assign w_at_sp  = (r_tick_cnt == C_SP);
    assign w_sample = r_rx_s;
`endif

    // FSM state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_armed    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    // Next-state logic. Everything except arming is frozen without baud_tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_armed_nxt = r_armed;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (r_rx_s) w_armed_nxt = 1'b1;
                if (baud_tick && !r_rx_s && r_armed) w_state_nxt = S_START;
            end
            S_START: if (baud_tick) begin
                w_tick_nxt = r_tick_cnt + TW'(1);
                if (w_at_sp && w_sample) begin
                    // False start: abandon quietly.
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end else if (w_wrap) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: if (baud_tick) begin
                w_tick_nxt = r_tick_cnt + TW'(1);
                if (w_at_sp) w_shift_en = 1'b1;
                if (w_wrap) begin
                    if (r_bit_cnt == C_BIT_LAST) w_state_nxt = S_PARITY;
                    else                         w_bit_nxt   = r_bit_cnt + BW'(1);
                end
            end
            S_PARITY: if (baud_tick) begin
                w_tick_nxt = r_tick_cnt + TW'(1);
                if (w_at_sp) w_par_en = 1'b1;
                if (w_wrap)  w_state_nxt = S_STOP;
            end
            S_STOP: if (baud_tick) begin
                w_tick_nxt = r_tick_cnt + TW'(1);
                if (w_at_sp) begin
                    // Leave half a bit early so the next start edge is caught;
                    // a low stop bit disarms until the line returns high.
                    w_load      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                    w_armed_nxt = w_sample;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: shift register, parity latch and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_rx_data     <= '0;
            r_rx_parity   <= 1'b0;
            r_parity_load <= 1'b0;
            r_stop_error  <= 1'b0;
        end else begin
            // Shift in from the MSB end so the first bit ends up in bit 0.
            if (w_shift_en) r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
            if (w_par_en)   r_par   <= w_sample;
            r_parity_load <= w_load;
            if (w_load) begin
                r_rx_data    <= r_shift;
                r_rx_parity  <= r_par;
                r_stop_error <= ~w_sample;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_parity   = r_rx_parity;
    assign parity_load = r_parity_load;
    assign stop_error  = r_stop_error;
    assign rx_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
